// File: rtl/sad_read_sched.sv
// rtl/sad_read_sched.sv - SAD engine RAM read scheduler (reference/candidate walk)
//
// Once the block RAM is full, walks the RAM read address through the reference
// block and every candidate position of the search window. Each read cycle
// alternates one reference pixel with one candidate pixel. Strobes are delayed
// one cycle so that they line up with the RAM read data.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   ram_full  loader reports RAM loaded (level)
//   start     one-cycle request to run a full search (honoured only when idle)
//   addr      registered RAM read address
//   ref_stb   RAM data this cycle is a reference pixel
//   cand_stb  RAM data this cycle is a candidate pixel
//   sad_clr   first pixel pair of a candidate (with its first ref_stb)
//   sad_last  last pixel pair of a candidate (with its last cand_stb)
//   cand_idx  candidate number cy*RANGE+cx, valid while strobes are high
//   busy      high from start acceptance until done
//   done      one-cycle pulse after the final candidate
module sad_read_sched #(
  parameter int ADDR_W    = 9,
  parameter int BLK       = 4,
  parameter int RANGE     = 4,
  parameter int REF_BASE  = 0,
  parameter int SRCH_BASE = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ram_full,
  input  logic                             start,
  output logic [ADDR_W-1:0]                addr,
  output logic                             ref_stb,
  output logic                             cand_stb,
  output logic                             sad_clr,
  output logic                             sad_last,
  output logic [$clog2(RANGE*RANGE)-1:0]   cand_idx,
  output logic                             busy,
  output logic                             done
);

  localparam int AW     = ADDR_W + 2;
  localparam int SRCH_W = BLK + RANGE - 1;
  localparam int PW     = (BLK > 1) ? $clog2(BLK) : 1;
  localparam int CW     = (RANGE > 1) ? $clog2(RANGE) : 1;
  localparam int IW     = $clog2(RANGE*RANGE);

  localparam logic [PW-1:0] P_MAX = PW'(BLK - 1);
  localparam logic [CW-1:0] C_MAX = CW'(RANGE - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state;
  logic          ph;
  logic [PW-1:0] px, py;
  logic [CW-1:0] cx, cy;

  // Issue-stage flags travel with addr; the output strobes are these delayed
  // by one more cycle to match the RAM read latency.
  logic          iss_ref, iss_cand, iss_clr, iss_last;
  logic [IW-1:0] iss_idx;

  logic              px_end, py_end, cx_end, cy_end;
  logic              last_rd, first_pair, last_pair;
  logic [ADDR_W-1:0] rd_addr;
  logic [IW-1:0]     idx_now;

  always_comb begin
    px_end     = (px == P_MAX);
    py_end     = (py == P_MAX);
    cx_end     = (cx == C_MAX);
    cy_end     = (cy == C_MAX);
    last_rd    = ph & px_end & py_end & cx_end & cy_end;
    first_pair = ~ph & (px == '0) & (py == '0);
    last_pair  = ph & px_end & py_end;
    // Computed at ADDR_W+2 bits so intermediate sums cannot wrap, then truncated.
    rd_addr = ADDR_W'(ph ?
        (AW'(SRCH_BASE) + (AW'(cy) + AW'(py)) * AW'(SRCH_W) + AW'(cx) + AW'(px)) :
        (AW'(REF_BASE) + AW'(py) * AW'(BLK) + AW'(px)));
    idx_now = IW'(cy) * IW'(RANGE) + IW'(cx);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      ph       <= 1'b0;
      px       <= '0;
      py       <= '0;
      cx       <= '0;
      cy       <= '0;
      addr     <= '0;
      iss_ref  <= 1'b0;
      iss_cand <= 1'b0;
      iss_clr  <= 1'b0;
      iss_last <= 1'b0;
      iss_idx  <= '0;
      ref_stb  <= 1'b0;
      cand_stb <= 1'b0;
      sad_clr  <= 1'b0;
      sad_last <= 1'b0;
      cand_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      iss_ref  <= 1'b0;
      iss_cand <= 1'b0;
      iss_clr  <= 1'b0;
      iss_last <= 1'b0;
      ref_stb  <= iss_ref;
      cand_stb <= iss_cand;
      sad_clr  <= iss_clr;
      sad_last <= iss_last;
      cand_idx <= iss_idx;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          // The cycle that shows done is still part of the previous run, so a
          // start seen there is dropped too.
          if (start && !done) begin
            busy  <= 1'b1;
            state <= ram_full ? S_RUN : S_WAIT;
          end
        end
        S_WAIT: begin
          if (ram_full) state <= S_RUN;
        end
        S_RUN: begin
          addr     <= rd_addr;
          iss_ref  <= ~ph;
          iss_cand <= ph;
          iss_clr  <= first_pair;
          iss_last <= last_pair;
          iss_idx  <= idx_now;
          // Counters wrap naturally, so they are all zero again after the last read.
          ph <= ~ph;
          if (ph) begin
            px <= px_end ? '0 : px + 1'b1;
            if (px_end) begin
              py <= py_end ? '0 : py + 1'b1;
              if (py_end) begin
                cx <= cx_end ? '0 : cx + 1'b1;
                if (cx_end) cy <= cy_end ? '0 : cy + 1'b1;
              end
            end
          end
          if (last_rd) state <= S_DRAIN;
        end
        S_DRAIN: begin
          state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
